// File: rtl/gamepad_pmod_pkg.sv
// Shared constants for the gamepad PMOD emitter: button bit positions, frame sizes, FSM states.
package gamepad_pmod_pkg;
  localparam int WORD_BITS  = 12;
  localparam int FRAME_BITS = 24;
  localparam logic [WORD_BITS-1:0] ABSENT_WORD = 12'hFFF;

  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    LATCH = 3'd4,
    GAP   = 3'd5
  } state_e;
endpackage

// File: rtl/gamepad_pmod_socd_filter.sv
// Clears opposing direction pairs (up+down, left+right) in one 12-bit controller word.
module gamepad_pmod_socd_filter
  import gamepad_pmod_pkg::*;
(
  input  logic [WORD_BITS-1:0] word_i,
  output logic [WORD_BITS-1:0] word_o
);
  always_comb begin
    word_o = word_i;
    if (word_i[BTN_UP] && word_i[BTN_DOWN]) begin
      word_o[BTN_UP]   = 1'b0;
      word_o[BTN_DOWN] = 1'b0;
    end
    if (word_i[BTN_LEFT] && word_i[BTN_RIGHT]) begin
      word_o[BTN_LEFT]  = 1'b0;
      word_o[BTN_RIGHT] = 1'b0;
    end
  end
endmodule

// File: rtl/gamepad_pmod_emitter.sv
// Gamepad PMOD transmitter: shifts {p2, p1} MSB first, then pulses latch and idles.
// Define GAMEPAD_PMOD_EMITTER_SOCD_EN to clean opposing directions at LOAD.
module gamepad_pmod_emitter
  import gamepad_pmod_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WORD_BITS-1:0] buttons_p1,
  input  logic [WORD_BITS-1:0] buttons_p2,
  input  logic                 p2_present,
  output logic                 pmod_clk,
  output logic                 pmod_data,
  output logic                 pmod_latch,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int HCW = $clog2(CLK_DIV + 1);
  localparam int GCW = $clog2(IDLE_CYCLES + 1);
  // The single IDLE cycle is the last cycle of the idle gap, so back-to-back
  // frames repeat every 1 + 2*CLK_DIV*24 + CLK_DIV + IDLE_CYCLES cycles.
  localparam int GAP_LEN = IDLE_CYCLES - 1;
  localparam logic [HCW-1:0] HC_LAST  = HCW'(CLK_DIV - 1);
  localparam logic [GCW-1:0] GC_LAST  = GCW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [4:0]     BIT_LAST = 5'(FRAME_BITS - 1);

  logic [WORD_BITS-1:0] p1_w, p2_raw, p2_w;

`ifdef GAMEPAD_PMOD_EMITTER_SOCD_EN
  gamepad_pmod_socd_filter u_socd_p1 (.word_i(buttons_p1), .word_o(p1_w));
  gamepad_pmod_socd_filter u_socd_p2 (.word_i(buttons_p2), .word_o(p2_raw));
`else
  assign p1_w   = buttons_p1;
  assign p2_raw = buttons_p2;
`endif

  assign p2_w = p2_present ? p2_raw : ABSENT_WORD;

  state_e                state_q, state_d;
  logic [HCW-1:0]        hc_q, hc_d;
  logic [4:0]            bit_q, bit_d;
  logic [GCW-1:0]        gc_q, gc_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  fd_q, fd_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hc_q    <= '0;
      bit_q   <= '0;
      gc_q    <= '0;
      shreg_q <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bit_q   <= bit_d;
      gc_q    <= gc_d;
      shreg_q <= shreg_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q + 1'b1;
    bit_d   = bit_q;
    gc_d    = gc_q;
    shreg_d = shreg_q;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = LOAD;
      LOAD: begin
        shreg_d = {p2_w, p1_w};
        bit_d   = '0;
        state_d = LO;
      end
      LO: if (hc_q == HC_LAST) state_d = HI;
      HI: if (hc_q == HC_LAST) begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        bit_d   = bit_q + 5'd1;
        state_d = (bit_q == BIT_LAST) ? LATCH : LO;
      end
      LATCH: if (hc_q == HC_LAST) begin
        fd_d    = 1'b1;
        state_d = (GAP_LEN > 0) ? GAP : IDLE;
      end
      GAP: begin
        gc_d = gc_q + 1'b1;
        if (gc_q == GC_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      hc_d = '0;
      gc_d = '0;
    end
  end

  assign pmod_clk   = (state_q == HI);
  assign pmod_data  = ((state_q == LO) || (state_q == HI)) && shreg_q[FRAME_BITS-1];
  assign pmod_latch = (state_q == LATCH);
  assign busy       = (state_q != IDLE);
  assign frame_done = fd_q;
endmodule
